// File: rtl/batrider_pcm_fetch.sv
// batrider_pcm_fetch: two-channel OKI PCM ROM fetcher with a one-line cache per channel over a shared 32-bit SDRAM read port
//
// Ports:
//   CLK96, RESET96_N       system clock, synchronous active-low reset
//   PCMn_CS, PCMn_ADDR     channel n byte request (n = 0, 1)
//   PCMn_DOUT, PCMn_OK     channel n registered byte data and valid flag
//   SDR_CS, SDR_ADDR       SDRAM 32-bit word read request, held until SDR_OK
//   SDR_OK, SDR_DATA       SDRAM read completion and data
module batrider_pcm_fetch #(
    parameter int AW         = 21,
    parameter int LINE_BYTES = 4
) (
    input  logic          CLK96,
    input  logic          RESET96_N,
    input  logic          PCM0_CS,
    input  logic [AW-1:0] PCM0_ADDR,
    output logic [7:0]    PCM0_DOUT,
    output logic          PCM0_OK,
    input  logic          PCM1_CS,
    input  logic [AW-1:0] PCM1_ADDR,
    output logic [7:0]    PCM1_DOUT,
    output logic          PCM1_OK,
    output logic          SDR_CS,
    output logic [AW-3:0] SDR_ADDR,
    input  logic          SDR_OK,
    input  logic [31:0]   SDR_DATA
);
    localparam int OW = $clog2(LINE_BYTES);
    localparam int TW = AW - OW;

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1} state_t;

    logic [1:0]    cs;
    logic [1:0]    hit;
    logic [1:0]    pend;
    logic [AW-1:0] addr [2];
    logic          grant;
    logic          cur;

    state_t        state_q;
    logic          rr_q;
    logic          sdr_cs_q;
    logic [TW-1:0] sdr_addr_q;
    logic [1:0]    valid_q;
    logic [1:0]    ok_q;
    logic [TW-1:0] tag_q  [2];
    logic [31:0]   line_q [2];
    logic [7:0]    dout_q [2];

    function automatic logic [7:0] pick(input logic [31:0] w, input logic [OW-1:0] o);
        return 8'(w >> {o, 3'b000});
    endfunction

    assign cs      = {PCM1_CS, PCM0_CS};
    assign addr[0] = PCM0_ADDR;
    assign addr[1] = PCM1_ADDR;

    always_comb begin
        hit = '0;
        for (int n = 0; n < 2; n++) begin
            hit[n] = cs[n] & valid_q[n] & (tag_q[n] == addr[n][AW-1:OW]);
        end
    end

    // A miss is simply a request that the line cannot serve right now; a
    // stale fill therefore re-raises the request without extra bookkeeping.
    assign pend  = cs & ~hit;
    // rr_q names the channel preferred on a tie, i.e. the one not served last.
    assign grant = &pend ? rr_q : pend[1];
    assign cur   = (state_q == FETCH1);

    always_ff @(posedge CLK96) begin
        if (!RESET96_N) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            sdr_cs_q   <= 1'b0;
            sdr_addr_q <= '0;
            valid_q    <= '0;
            ok_q       <= '0;
            for (int n = 0; n < 2; n++) begin
                tag_q[n]  <= '0;
                line_q[n] <= '0;
                dout_q[n] <= '0;
            end
        end else begin
            ok_q <= hit;
            for (int n = 0; n < 2; n++) begin
                if (hit[n]) dout_q[n] <= pick(line_q[n], addr[n][OW-1:0]);
            end
            case (state_q)
                IDLE: begin
                    if (|pend) begin
                        state_q    <= grant ? FETCH1 : FETCH0;
                        sdr_cs_q   <= 1'b1;
                        sdr_addr_q <= addr[grant][AW-1:OW];
                    end
                end
                FETCH0, FETCH1: begin
                    // The tag is the frozen request address, not the live one,
                    // so an address that moved away during the fetch misses.
                    if (SDR_OK) begin
                        valid_q[cur] <= 1'b1;
                        tag_q[cur]   <= sdr_addr_q;
                        line_q[cur]  <= SDR_DATA;
                        sdr_cs_q     <= 1'b0;
                        rr_q         <= ~cur;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    sdr_cs_q <= 1'b0;
                end
            endcase
        end
    end

    assign PCM0_OK   = ok_q[0];
    assign PCM1_OK   = ok_q[1];
    assign PCM0_DOUT = dout_q[0];
    assign PCM1_DOUT = dout_q[1];
    assign SDR_CS    = sdr_cs_q;
    assign SDR_ADDR  = sdr_addr_q;
endmodule

// File: doc/batrider_pcm_fetch.md
Name: batrider_pcm_fetch

Overview:
- Downstream consumer of the sound block's two OKI ROM request ports: PCM_ADDR/PCM_CS and PCM1_ADDR/PCM1_CS.
- Returns PCM_DOUT/PCM_OK and PCM1_DOUT/PCM1_OK.
- Arbitrates both channels onto one 32-bit SDRAM read port, with a one-line (4-byte) cache per channel. ADPCM nibbles are fetched sequentially, so most reads hit the cache and skip the SDRAM.

Parameters:
- AW, 21, byte address width of each PCM channel.
- LINE_BYTES, 4, bytes per cache line. Fixed value; the SDRAM word is 32 bits.

Ports:
- CLK96  in  1  system clock; all logic on rising edge.
- RESET96_N  in  1  synchronous, active-low reset.
- PCM0_CS  in  1  channel 0 request enable.
- PCM0_ADDR  in  AW  channel 0 byte address, after NMK112 banking.
- PCM0_DOUT  out  8  channel 0 byte data.
- PCM0_OK  out  1  channel 0 data valid for the current PCM0_ADDR.
- PCM1_CS  in  1  channel 1 request enable.
- PCM1_ADDR  in  AW  channel 1 byte address.
- PCM1_DOUT  out  8  channel 1 byte data.
- PCM1_OK  out  1  channel 1 data valid.
- SDR_CS  out  1  SDRAM read request; held high until SDR_OK.
- SDR_ADDR  out  AW-2  SDRAM 32-bit word address.
- SDR_OK  in  1  SDRAM data valid; sampled only while SDR_CS is high.
- SDR_DATA  in  32  SDRAM read data.

Behaviour:
- Reset (RESET96_N low at a clock edge):
  - Both line valid bits cleared; FSM goes to IDLE.
  - SDR_CS=0, SDR_ADDR=0, PCMx_OK=0, PCMx_DOUT=0.
  - Round-robin pointer set to channel 0.
  - Reset mid-fetch abandons the fetch; a later SDR_OK is ignored because SDR_CS is already 0.
- Per-channel line state: valid bit, tag = ADDR[AW-1:2], 32-bit data.
- Hit: CS=1 and valid and tag==ADDR[AW-1:2].
  - Registered output: OK=1 and DOUT=byte ADDR[1:0] on the next edge.
  - Hit latency is 1 cycle.
- Byte select is little-endian: ADDR[1:0]=0 gives DATA[7:0]; 3 gives DATA[31:24].
- OK is recomputed every cycle against the current ADDR.
  - A change of ADDR to a different line drops OK to 0 on the next edge.
  - A change within the same line keeps OK=1 with the new byte.
- CS=0: OK=0 next cycle. DOUT holds its last value. Line contents are preserved.
- Miss: CS=1 and not a hit. The channel raises an internal pending flag.
- FSM states: IDLE, FETCH0, FETCH1.
  - IDLE: if exactly one channel is pending, go to FETCHn.
  - IDLE, both pending: grant the channel that was not served last (round robin), then go to FETCHn.
  - On entry to FETCHn: SDR_CS=1 and SDR_ADDR=PCMn_ADDR[AW-1:2] are registered on the transition edge. SDR_ADDR is frozen until completion.
  - FETCHn with SDR_OK=1: write SDR_DATA into line n, tag = the frozen SDR_ADDR, valid=1. Drop SDR_CS the same edge, update the round-robin pointer, return to IDLE.
  - The channel's OK rises one cycle after the fill, if its ADDR still matches the fetched tag.
- Minimum miss latency: 1 cycle to the request, plus SDRAM latency, plus 1 cycle to the fill, plus 1 cycle to OK.
- No back-to-back request: SDR_CS is low for at least 1 cycle between fetches.
- ADDR moves to another line during FETCHn: the fetch completes and fills with the stale tag. That fill produces no hit, so OK stays 0; the channel misses again and refetches.
- Simultaneous fill and hit on the other channel: both are served independently. The cache read port of each line is separate.
- A channel is never granted twice in a row while the other channel is pending.
- No writes and no flush are needed. Bank changes alter PCMx_ADDR, which forces a miss by tag compare.

Test Plan:
- Reset, then PCM0_CS=1, ADDR=0x000104; SDRAM returns 0xDDCCBBAA after 5 cycles:
  - SDR_ADDR=0x00041, SDR_CS held 5 cycles.
  - PCM0_OK=1 with DOUT=0xAA one cycle after the fill.
  - ADDR 0x105/0x106/0x107 then give 0xBB/0xCC/0xDD, each 1 cycle after the change, with no new SDR_CS.
- Both channels miss in the same cycle (ch0 0x000200, ch1 0x100300) -> ch0 is fetched first (word 0x00080), then ch1 (0x400C0). SDR_CS is low for at least one cycle between the fetches. Each OK rises only after its own fill.
- Channel 0 misses continuously (stream 0x0,0x4,0x8,...) while channel 1 misses -> grants alternate 0,1,0,1; neither channel waits more than one foreign fetch.
- During a ch0 fetch of 0x000400, ADDR changes to 0x000800 -> the 0x400 fill completes; PCM0_OK stays 0; a second fetch is issued for word 0x00200 and OK follows it.
- RESET96_N low for 1 cycle while SDR_CS=1, then SDR_OK pulses -> SDR_CS=0, no fill; the previously valid address now misses (valid cleared); all outputs are zero.
- PCM1_CS drops to 0 for 3 cycles at a cached address, then returns -> OK=0 during the gap; OK=1 again 1 cycle after CS returns; no SDRAM access.
